vram_write_queue: RTL and testbench

Buffers CPU stores to the screen memory window and hands them to the shared video RAM write port one at a time. It absorbs the variable write-acknowledge delay caused by scan-out reads having priority on the RAM. The CPU stalls only when the queue is full. Sits directly upstream of the shared VRAM write port: its `vram_*` outputs drive that port's `wren`/`waddr`/`wdata`, and it consumes `wrack`.

---
 rtl/vram_write_queue.sv | 53 +++++
 tb/tb_vram_write_queue.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/vram_write_queue.sv
// vram_write_queue: FIFO of CPU stores to the screen window (0x4000-0x5FFF) feeding the shared VRAM write port.
// Ports: clk/reset (async, active-high); cpu_wren/cpu_addr/cpu_din store in, cpu_stall when the queue is full;
// vram_wren/vram_waddr/vram_wdata present the head entry until vram_wrack pops it; level/empty report occupancy.
module vram_write_queue #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_wren,
    input  logic [14:0]              cpu_addr,
    input  logic [15:0]              cpu_din,
    output logic                     cpu_stall,
    output logic                     vram_wren,
    output logic [13:0]              vram_waddr,
    output logic [15:0]              vram_wdata,
    input  logic                     vram_wrack,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);
    logic [AW:0] wptr, rptr;
    logic [13:0] addr_mem [DEPTH];
    logic [15:0] data_mem [DEPTH];
    logic hit, full, push, pop;
    // Pointers carry one extra bit so that full and empty are distinguishable.
    assign level      = wptr - rptr;
    assign empty      = level == '0;
    assign full       = level == FULL_LEVEL;
    assign hit        = cpu_addr[14:13] == 2'b10;
    assign cpu_stall  = cpu_wren & hit & full;
    assign push       = cpu_wren & hit & !full;
    assign vram_wren  = !empty;
    assign pop        = vram_wren & vram_wrack;
    // Storage is never reset, so the head is masked to keep the outputs at zero while empty.
    assign vram_waddr = empty ? '0 : addr_mem[rptr[AW-1:0]];
    assign vram_wdata = empty ? '0 : data_mem[rptr[AW-1:0]];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW + 1)'(1);
            if (pop) rptr <= rptr + (AW + 1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wptr[AW-1:0]] <= {1'b0, cpu_addr[12:0]};
            data_mem[wptr[AW-1:0]] <= cpu_din;
        end
    end
endmodule

// File: tb/tb_vram_write_queue.sv
// tb_vram_write_queue: queue-model checker plus directed stores for vram_write_queue.
module tb_vram_write_queue;
    localparam int DEPTH = 8;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_wren = 1'b0;
    logic [14:0] cpu_addr = '0;
    logic [15:0] cpu_din = '0;
    logic        cpu_stall;
    logic        vram_wren;
    logic [13:0] vram_waddr;
    logic [15:0] vram_wdata;
    logic        vram_wrack = 1'b0;
    logic [3:0]  level;
    logic        empty;
    int n_cmp = 0;
    int n_fail = 0;
    logic [29:0] q[$];

    vram_write_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_stall(cpu_stall), .vram_wren(vram_wren), .vram_waddr(vram_waddr), .vram_wdata(vram_wdata),
        .vram_wrack(vram_wrack), .level(level), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a queue of {addr14, data16}; accepts window stores unless holding DEPTH entries.
    always @(posedge clk or posedge reset) begin
        if (reset) q.delete();
        else begin
            automatic bit was_full = q.size() == DEPTH;
            automatic bit do_pop = q.size() > 0 && vram_wrack;
            automatic bit do_push = cpu_wren && cpu_addr >= 15'h4000 && cpu_addr <= 15'h5FFF && !was_full;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back({1'b0, cpu_addr[12:0], cpu_din});
        end
    end

    always @(negedge clk) begin
        automatic bit win = cpu_addr >= 15'h4000 && cpu_addr <= 15'h5FFF;
        chk("m_level", 32'(level), 32'(q.size()));
        chk("m_empty", 32'(empty), 32'(q.size() == 0));
        chk("m_wren", 32'(vram_wren), 32'(q.size() != 0));
        chk("m_waddr", 32'(vram_waddr), q.size() ? 32'(q[0][29:16]) : 32'd0);
        chk("m_wdata", 32'(vram_wdata), q.size() ? 32'(q[0][15:0]) : 32'd0);
        chk("m_stall", 32'(cpu_stall), 32'(cpu_wren && win && q.size() == DEPTH));
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic store(input logic [14:0] a, input logic [15:0] d);
        cpu_wren = 1'b1;
        cpu_addr = a;
        cpu_din = d;
        tick();
        cpu_wren = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        reset = 1'b0;
        tick();
        store(15'h4005, 16'hBEEF);
        chk("one_wren", 32'(vram_wren), 32'd1);
        chk("one_waddr", 32'(vram_waddr), 32'h0005);
        chk("one_wdata", 32'(vram_wdata), 32'hBEEF);
        chk("one_level", 32'(level), 32'd1);
        vram_wrack = 1'b1;
        tick();
        vram_wrack = 1'b0;
        chk("one_empty", 32'(empty), 32'd1);
        chk("one_wren0", 32'(vram_wren), 32'd0);
        cpu_wren = 1'b1;
        cpu_addr = 15'h3FFF;
        #1;
        chk("oow_stall_lo", 32'(cpu_stall), 32'd0);
        tick();
        cpu_addr = 15'h6000;
        #1;
        chk("oow_stall_hi", 32'(cpu_stall), 32'd0);
        tick();
        cpu_wren = 1'b0;
        chk("oow_level", 32'(level), 32'd0);
        for (int i = 0; i < 8; i++) store(15'h4100 + 15'(i), 16'h1000 + 16'(i));
        chk("fill_level", 32'(level), 32'd8);
        cpu_wren = 1'b1;
        cpu_addr = 15'h4108;
        cpu_din = 16'h1008;
        #1;
        chk("full_stall", 32'(cpu_stall), 32'd1);
        vram_wrack = 1'b1;
        tick();
        vram_wrack = 1'b0;
        chk("after_ack_level", 32'(level), 32'd7);
        chk("after_ack_stall", 32'(cpu_stall), 32'd0);
        tick();
        cpu_wren = 1'b0;
        chk("refill_level", 32'(level), 32'd8);
        for (int i = 0; i < 8; i++) begin
            tick();
            vram_wrack = 1'b1;
            chk("drain_addr", 32'(vram_waddr), 32'h0101 + 32'(i));
            chk("drain_data", 32'(vram_wdata), 32'h1001 + 32'(i));
            tick();
            vram_wrack = 1'b0;
        end
        chk("drain_empty", 32'(empty), 32'd1);
        for (int i = 0; i < 3; i++) store(15'h5000 + 15'(i), 16'h2000 + 16'(i));
        cpu_wren = 1'b1;
        cpu_addr = 15'h5003;
        cpu_din = 16'h2003;
        vram_wrack = 1'b1;
        tick();
        cpu_wren = 1'b0;
        vram_wrack = 1'b0;
        chk("pp_level", 32'(level), 32'd3);
        chk("pp_head", 32'(vram_waddr), 32'h1001);
        for (int k = 0; k < 12 && !empty; k++) begin
            vram_wrack = k[0];
            tick();
        end
        vram_wrack = 1'b0;
        chk("pp_drained", 32'(empty), 32'd1);
        for (int i = 0; i < 5; i++) store(15'h4200 + 15'(i), 16'h3000 + 16'(i));
        chk("mid_level", 32'(level), 32'd5);
        vram_wrack = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mr_wren", 32'(vram_wren), 32'd0);
        chk("mr_level", 32'(level), 32'd0);
        chk("mr_empty", 32'(empty), 32'd1);
        chk("mr_waddr", 32'(vram_waddr), 32'd0);
        chk("mr_wdata", 32'(vram_wdata), 32'd0);
        chk("mr_stall", 32'(cpu_stall), 32'd0);
        vram_wrack = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b0;
        tick();
        store(15'h4ABC, 16'h1234);
        chk("post_level", 32'(level), 32'd1);
        chk("post_waddr", 32'(vram_waddr), 32'h0ABC);
        vram_wrack = 1'b1;
        tick();
        vram_wrack = 1'b0;
        chk("post_empty", 32'(empty), 32'd1);
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
